// File: rtl/getir_ps_uretici.sv
// Fetch-PC generator feeding the ongorucu predictor, with an in-order in-flight prediction queue.
// Optional ISTATISTIK_EN adds saturating branch / mispredict counters (dallan_sayac, yanlis_sayac).
module getir_ps_uretici #(
    parameter int unsigned       PC_LEN          = 32,
    parameter logic [PC_LEN-1:0] RESET_PS        = '0,
    parameter int unsigned       KUYRUK_DERINLIK = 4
) (
    input  logic              clk,
    input  logic              rst,
    output logic [PC_LEN-1:0] getir_ps,
    output logic              getir_gecerli,
    input  logic              ongoru_dallan,
    input  logic [PC_LEN-1:0] ongoru_dallan_ps,
    input  logic              cozme_hazir,
    output logic              getir_ongoru,
    input  logic              yurut_gecerli,
    input  logic [PC_LEN-1:0] yurut_ps,
    input  logic              yurut_dallanma,
    input  logic              yurut_dallan,
    input  logic [PC_LEN-1:0] yurut_dallan_ps,
    output logic              yonlendir,
    output logic              guncelle_gecerli,
`ifdef ISTATISTIK_EN
    output logic [31:0]       dallan_sayac,
    output logic [31:0]       yanlis_sayac,
`endif
    output logic              hata
);

    localparam int unsigned PTR_W = (KUYRUK_DERINLIK > 1) ? $clog2(KUYRUK_DERINLIK) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]  DERINLIK = CNT_W'(KUYRUK_DERINLIK);
    localparam logic [PC_LEN-1:0] ADIM     = PC_LEN'(4);

    typedef struct packed {
        logic [PC_LEN-1:0] ps;
        logic              dallan;
        logic [PC_LEN-1:0] hedef;
    } kuyruk_girdi_t;

    kuyruk_girdi_t     kuyruk_q [KUYRUK_DERINLIK];
    logic [PTR_W-1:0]  yaz_ptr_q;
    logic [PTR_W-1:0]  oku_ptr_q;
    logic [CNT_W-1:0]  sayi_q;

    kuyruk_girdi_t     bas;
    kuyruk_girdi_t     yeni_girdi;
    logic              bas_gecerli;
    logic              dolu;
    logic              mis;
    logic              it;
    logic              cek;
    logic              hata_set;
    logic [PC_LEN-1:0] getir_ps_d;
    logic [PTR_W-1:0]  yaz_ptr_d;
    logic [PTR_W-1:0]  oku_ptr_d;
    logic [CNT_W-1:0]  sayi_d;

    assign bas = kuyruk_q[oku_ptr_q];

    // Handshake, mispredict detection and next-PC selection
    always_comb begin
        bas_gecerli      = 1'b0;
        dolu             = 1'b0;
        mis              = 1'b0;
        getir_gecerli    = 1'b0;
        getir_ongoru     = ongoru_dallan;
        yonlendir        = 1'b0;
        guncelle_gecerli = 1'b0;
        it               = 1'b0;
        cek              = 1'b0;
        hata_set         = 1'b0;
        yeni_girdi       = '{ps: getir_ps, dallan: ongoru_dallan, hedef: ongoru_dallan_ps};
        getir_ps_d       = getir_ps;
        yaz_ptr_d        = yaz_ptr_q;
        oku_ptr_d        = oku_ptr_q;
        sayi_d           = sayi_q;

        bas_gecerli = (sayi_q != '0);
        dolu        = (sayi_q == DERINLIK);

        if (!rst) begin
            mis = yurut_gecerli && bas_gecerli &&
                  ((bas.dallan != yurut_dallan) ||
                   (yurut_dallan && (bas.hedef != yurut_dallan_ps)));
            yonlendir        = mis;
            guncelle_gecerli = yurut_gecerli && yurut_dallanma && bas_gecerli;
            getir_gecerli    = !dolu && !mis;
            it               = getir_gecerli && cozme_hazir;
            cek              = yurut_gecerli && bas_gecerli;
            hata_set         = yurut_gecerli && (!bas_gecerli || (bas.ps != yurut_ps));
        end

        if (mis) begin
            getir_ps_d = yurut_dallan ? yurut_dallan_ps : (yurut_ps + ADIM);
        end else if (it) begin
            getir_ps_d = ongoru_dallan ? ongoru_dallan_ps : (getir_ps + ADIM);
        end

        if (cek) begin
            oku_ptr_d = oku_ptr_q + PTR_W'(1);
        end
        if (it) begin
            yaz_ptr_d = yaz_ptr_q + PTR_W'(1);
        end
        sayi_d = sayi_q + CNT_W'(it) - CNT_W'(cek);

        // Flush: drop everything behind the mispredicted head
        if (mis) begin
            yaz_ptr_d = oku_ptr_d;
            sayi_d    = '0;
        end
    end

    // Control state
    always_ff @(posedge clk) begin
        if (rst) begin
            getir_ps  <= RESET_PS;
            yaz_ptr_q <= '0;
            oku_ptr_q <= '0;
            sayi_q    <= '0;
            hata      <= 1'b0;
        end else begin
            getir_ps  <= getir_ps_d;
            yaz_ptr_q <= yaz_ptr_d;
            oku_ptr_q <= oku_ptr_d;
            sayi_q    <= sayi_d;
            hata      <= hata | hata_set;
        end
    end

    // Queue storage; contents are qualified by sayi_q so no reset needed
    always_ff @(posedge clk) begin
        if (it) begin
            kuyruk_q[yaz_ptr_q] <= yeni_girdi;
        end
    end

`ifdef ISTATISTIK_EN
    // Saturating event counters
    always_ff @(posedge clk) begin
        if (rst) begin
            dallan_sayac <= '0;
            yanlis_sayac <= '0;
        end else begin
            if (guncelle_gecerli && (dallan_sayac != '1)) begin
                dallan_sayac <= dallan_sayac + 32'd1;
            end
            if (mis && (yanlis_sayac != '1)) begin
                yanlis_sayac <= yanlis_sayac + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_getir_ps_uretici.sv
// Directed bench for getir_ps_uretici: reset, prediction, mispredict flush, full queue,
// streaming resolve, empty-pop error, PC wrap and taken-target mispredict.
module tb_getir_ps_uretici;

    logic        clk;
    logic        rst;
    logic [31:0] getir_ps;
    logic        getir_gecerli;
    logic        ongoru_dallan;
    logic [31:0] ongoru_dallan_ps;
    logic        cozme_hazir;
    logic        getir_ongoru;
    logic        yurut_gecerli;
    logic [31:0] yurut_ps;
    logic        yurut_dallanma;
    logic        yurut_dallan;
    logic [31:0] yurut_dallan_ps;
    logic        yonlendir;
    logic        guncelle_gecerli;
    logic        hata;
`ifdef ISTATISTIK_EN
    logic [31:0] dallan_sayac;
    logic [31:0] yanlis_sayac;
`endif

    int n_test;
    int n_fail;

    getir_ps_uretici #(
        .PC_LEN          (32),
        .RESET_PS        (32'h0000_0000),
        .KUYRUK_DERINLIK (4)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .getir_ps         (getir_ps),
        .getir_gecerli    (getir_gecerli),
        .ongoru_dallan    (ongoru_dallan),
        .ongoru_dallan_ps (ongoru_dallan_ps),
        .cozme_hazir      (cozme_hazir),
        .getir_ongoru     (getir_ongoru),
        .yurut_gecerli    (yurut_gecerli),
        .yurut_ps         (yurut_ps),
        .yurut_dallanma   (yurut_dallanma),
        .yurut_dallan     (yurut_dallan),
        .yurut_dallan_ps  (yurut_dallan_ps),
        .yonlendir        (yonlendir),
        .guncelle_gecerli (guncelle_gecerli),
`ifdef ISTATISTIK_EN
        .dallan_sayac     (dallan_sayac),
        .yanlis_sayac     (yanlis_sayac),
`endif
        .hata             (hata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic kontrol(input string etiket, input logic [31:0] gozlenen, input logic [31:0] beklenen);
        n_test++;
        if (gozlenen !== beklenen) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", etiket, gozlenen, beklenen);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_test           = 0;
        n_fail           = 0;
        rst              = 1'b1;
        ongoru_dallan    = 1'b0;
        ongoru_dallan_ps = '0;
        cozme_hazir      = 1'b0;
        yurut_gecerli    = 1'b0;
        yurut_ps         = '0;
        yurut_dallanma   = 1'b0;
        yurut_dallan     = 1'b0;
        yurut_dallan_ps  = '0;

        // Reset
        repeat (3) tick();
        #1;
        kontrol("rst_ps",       getir_ps, 32'h0);
        kontrol("rst_gecerli",  32'(getir_gecerli), 32'd0);
        kontrol("rst_yonlendir", 32'(yonlendir), 32'd0);
        kontrol("rst_guncelle", 32'(guncelle_gecerli), 32'd0);
        kontrol("rst_hata",     32'(hata), 32'd0);

        rst         = 1'b0;
        cozme_hazir = 1'b1;
        #1;
        kontrol("ilk_gecerli", 32'(getir_gecerli), 32'd1);
        kontrol("ilk_ps",      getir_ps, 32'h0);
        tick();
        kontrol("ps_4", getir_ps, 32'h4);
        tick();
        kontrol("ps_8", getir_ps, 32'h8);

        // Predicted taken at PC 8
        ongoru_dallan    = 1'b1;
        ongoru_dallan_ps = 32'h40;
        #1;
        kontrol("getir_ongoru", 32'(getir_ongoru), 32'd1);
        tick();
        kontrol("ongoru_hedef", getir_ps, 32'h40);
        ongoru_dallan = 1'b0;
        cozme_hazir   = 1'b0;
        #1;
        kontrol("durak_gecerli", 32'(getir_gecerli), 32'd1);
        tick();
        kontrol("durak_ps", getir_ps, 32'h40);

        // Resolve PCs 0 and 4 correctly as non-branches
        yurut_gecerli = 1'b1;
        yurut_ps      = 32'h0;
        #1;
        kontrol("dogru0_yonlendir", 32'(yonlendir), 32'd0);
        kontrol("dogru0_guncelle", 32'(guncelle_gecerli), 32'd0);
        tick();
        yurut_ps = 32'h4;
        tick();

        // Resolve PC 8 not-taken: mispredict
        yurut_ps       = 32'h8;
        yurut_dallanma = 1'b1;
        yurut_dallan   = 1'b0;
        #1;
        kontrol("mis_yonlendir", 32'(yonlendir), 32'd1);
        kontrol("mis_guncelle",  32'(guncelle_gecerli), 32'd1);
        kontrol("mis_gecerli",   32'(getir_gecerli), 32'd0);
        tick();
        yurut_gecerli  = 1'b0;
        yurut_dallanma = 1'b0;
        #1;
        kontrol("mis_yeni_ps",  getir_ps, 32'hC);
        kontrol("mis_sonra_gecerli", 32'(getir_gecerli), 32'd1);

        // Fill: flushed queue takes exactly 4 pushes
        cozme_hazir = 1'b1;
        repeat (3) tick();
        kontrol("dolu3_ps", getir_ps, 32'h18);
        kontrol("dolu3_gecerli", 32'(getir_gecerli), 32'd1);
        tick();
        kontrol("dolu4_ps", getir_ps, 32'h1C);
        kontrol("dolu4_gecerli", 32'(getir_gecerli), 32'd0);
        tick();
        kontrol("dolu_tut_ps", getir_ps, 32'h1C);

        // Pop from full: no bypass within the cycle
        yurut_gecerli = 1'b1;
        yurut_ps      = 32'hC;
        #1;
        kontrol("cek_bypass_yok", 32'(getir_gecerli), 32'd0);
        kontrol("cek_yonlendir", 32'(yonlendir), 32'd0);
        tick();
        kontrol("cek_sonra_gecerli", 32'(getir_gecerli), 32'd1);
        kontrol("cek_sonra_ps", getir_ps, 32'h1C);

        // Streaming push+pop with correctly predicted not-taken branches
        yurut_dallanma = 1'b1;
        yurut_dallan   = 1'b0;
        for (int k = 0; k < 10; k++) begin
            yurut_ps = 32'h10 + 32'(4 * k);
            #1;
            kontrol("akis_gecerli", 32'(getir_gecerli), 32'd1);
            kontrol("akis_yonlendir", 32'(yonlendir), 32'd0);
            kontrol("akis_guncelle", 32'(guncelle_gecerli), 32'd1);
            tick();
        end
        yurut_gecerli  = 1'b0;
        yurut_dallanma = 1'b0;
        #1;
        kontrol("akis_son_ps", getir_ps, 32'h44);
        kontrol("akis_hata", 32'(hata), 32'd0);
`ifdef ISTATISTIK_EN
        kontrol("dallan_sayac", dallan_sayac, 32'd11);
        kontrol("yanlis_sayac", yanlis_sayac, 32'd1);
`endif

        // Reset mid-operation discards queue; then pop on empty
        rst         = 1'b1;
        cozme_hazir = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        kontrol("rst2_ps", getir_ps, 32'h0);
        kontrol("rst2_hata", 32'(hata), 32'd0);
        yurut_gecerli   = 1'b1;
        yurut_ps        = 32'h0;
        yurut_dallanma  = 1'b1;
        yurut_dallan    = 1'b1;
        yurut_dallan_ps = 32'h200;
        #1;
        kontrol("bos_yonlendir", 32'(yonlendir), 32'd0);
        kontrol("bos_guncelle", 32'(guncelle_gecerli), 32'd0);
        tick();
        yurut_gecerli = 1'b0;
        #1;
        kontrol("bos_hata", 32'(hata), 32'd1);
        kontrol("bos_ps", getir_ps, 32'h0);

        // PC wrap through predicted target at top of address space
        cozme_hazir      = 1'b1;
        ongoru_dallan    = 1'b1;
        ongoru_dallan_ps = 32'hFFFF_FFFC;
        tick();
        kontrol("sarma_hedef", getir_ps, 32'hFFFF_FFFC);
        ongoru_dallan = 1'b0;
        tick();
        kontrol("sarma_ps", getir_ps, 32'h0);

        // Taken with wrong target: redirect to actual target
        cozme_hazir     = 1'b0;
        yurut_gecerli   = 1'b1;
        yurut_ps        = 32'h0;
        yurut_dallanma  = 1'b1;
        yurut_dallan    = 1'b1;
        yurut_dallan_ps = 32'h100;
        #1;
        kontrol("hedef_mis", 32'(yonlendir), 32'd1);
        tick();
        yurut_gecerli = 1'b0;
        #1;
        kontrol("hedef_ps", getir_ps, 32'h100);
        kontrol("hata_yapiskan", 32'(hata), 32'd1);
`ifdef ISTATISTIK_EN
        kontrol("dallan_sayac2", dallan_sayac, 32'd1);
        kontrol("yanlis_sayac2", yanlis_sayac, 32'd1);
`endif

        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        kontrol("hata_temiz", 32'(hata), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_test, n_fail);
        $finish;
    end

endmodule
